// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro used by fetch_stage: FETCH_PERF_CNT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int          FETCH_DEPTH    = 2;

    // Instruction addresses are word aligned; low bits are simply discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries (instruction word + its PC).
// Clear wins over push and pop; a push into a full FIFO is only accepted
// when a pop frees the head in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  fetch_entry_t  i_wdata,
    output fetch_entry_t  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Entry storage; contents are only meaningful while counted as valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues pipelined word reads,
// buffers returned words with their PC and presents one per cycle to ID.
// Optional macro FETCH_PERF_CNT_EN adds FetchCount/BubbleCount outputs.
//
// Handshakes: a memory request transfers on a cycle where IMemReq and
// IMemAck are both high; IMemReq/IMemAddr hold until that cycle except on
// Redirect, which withdraws or retargets them. Read data returns as
// IMemRValid pulses in request order with no back-pressure. Towards ID,
// InstrValid is the valid and !Stall the ready: an instruction is consumed
// on a cycle with InstrValid & !Stall & !Redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int          DEPTH    = FETCH_DEPTH
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] InstrPC4,
    output logic        InstrValid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount,
`endif
    output logic [1:0]  o_dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_kill;
    logic [CW-1:0] w_kill_next;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_occupancy;
    logic          w_ack;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_room;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_head;

    // Words in flight plus words buffered never exceed DEPTH, so every
    // returning word has a FIFO slot and memory needs no back-pressure.
    assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_room      = ~w_full & (w_occupancy < (CW + 1)'(DEPTH));
    assign IMemReq     = (r_state != IDLE) & w_room;
    assign IMemAddr    = r_pc;
    assign w_ack       = IMemReq & IMemAck;

    // Returning words are dropped while older-than-redirect reads drain.
    assign w_drop  = IMemRValid & (r_kill != '0);
    assign w_push  = IMemRValid & (r_kill == '0) & ~Redirect;
    assign w_pop   = ~w_empty & ~Stall & ~Redirect;
    assign w_wdata = '{instr: IMemRData, pc: r_rsp_pc};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk   (Clock),
        .i_rst_n (nReset),
        .i_clear (Redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign InstrValid  = ~w_empty;
    assign Instr       = w_empty ? 32'h0 : w_head.instr;
    assign InstrPC     = w_empty ? 32'h0 : w_head.pc;
    assign InstrPC4    = w_empty ? 32'h0 : w_head.pc + 32'd4;
    assign o_dbg_state = r_state;

    // Kill count: on Redirect every read still owed (including one accepted
    // this cycle, excluding one returning this cycle) becomes stale.
    always_comb begin
        w_kill_next = r_kill;
        if (Redirect) begin
            w_kill_next = r_outstanding - CW'(IMemRValid) + CW'(w_ack);
        end else if (w_drop) begin
            w_kill_next = r_kill - CW'(1);
        end
    end

    // Next-state logic: DRAIN tracks whether stale reads are still owed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   if (Redirect && (w_kill_next != '0)) w_state_next = DRAIN;
            DRAIN:   if (w_kill_next == '0) w_state_next = FETCH;
            default: w_state_next = IDLE;
        endcase
    end

    // State, PC, response-PC, outstanding and kill registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state       <= IDLE;
            r_pc          <= align_pc(RESET_PC);
            r_rsp_pc      <= align_pc(RESET_PC);
            r_outstanding <= '0;
            r_kill        <= '0;
        end else begin
            r_state       <= w_state_next;
            r_kill        <= w_kill_next;
            r_outstanding <= r_outstanding + CW'(w_ack) - CW'(IMemRValid);
            if (Redirect) begin
                r_pc     <= align_pc(RedirectPC);
                r_rsp_pc <= align_pc(RedirectPC);
            end else begin
                if (w_ack)  r_pc     <= r_pc + 32'd4;
                if (w_push) r_rsp_pc <= r_rsp_pc + 32'd4;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    // Count instructions handed to ID and cycles where ID was starved.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_pop)             r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            if (w_empty && !Stall) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign FetchCount  = r_fetch_cnt;
    assign BubbleCount = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order memory responder and an
// ID-side reference PC model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic        IMemRValid = 1'b0;
  logic [31:0] IMemRData = 32'h0;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] InstrPC4;
  logic        InstrValid;
  logic [1:0]  o_dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemAck     (IMemAck),
    .IMemRValid  (IMemRValid),
    .IMemRData   (IMemRData),
    .Instr       (Instr),
    .InstrPC     (InstrPC),
    .InstrPC4    (InstrPC4),
    .InstrValid  (InstrValid),
`ifdef FETCH_PERF_CNT_EN
    .FetchCount  (FetchCount),
    .BubbleCount (BubbleCount),
`endif
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- counters and check helper ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_00A5;
  endfunction

  // ---------------- memory responder ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mem_q[$];
  int lat = 1;
  int ack_pct = 100;
  int rv_pct = 100;

  always @(negedge Clock) begin
    if (!nReset) begin
      mem_q.delete();
      IMemAck = 1'b0;
      IMemRValid = 1'b0;
      IMemRData = 32'h0;
    end else begin
      IMemAck = IMemReq && ($urandom_range(99) < ack_pct);
      if (IMemAck) begin
        mem_q.push_back('{addr: IMemAddr, due: cyc + 1 + lat});
        chk("mem_inflight_le_depth", 32'(mem_q.size() <= DEPTH), 32'd1);
      end
      IMemRValid = 1'b0;
      IMemRData = 32'h0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1 && $urandom_range(99) < rv_pct) begin
        IMemRValid = 1'b1;
        IMemRData = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
    end
  end

  // ---------------- ID-side scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc = 32'h0;
  int exp_fetch = 0;
  int exp_bubble = 0;
  int n_pop = 0;

  always @(negedge Clock) begin
    #3;
    if (!nReset) begin
      exp_pc = 32'h0;
      exp_fetch = 0;
      exp_bubble = 0;
      exp_q.delete();
    end else begin
      if (!InstrValid && !Stall) exp_bubble++;
      if (Redirect) begin
        exp_pc = {RedirectPC[31:2], 2'b00};
      end else if (InstrValid && !Stall) begin
        exp_q.push_back(exp_pc);
        chk("pop_pc", InstrPC, exp_q[0]);
        chk("pop_instr", Instr, mem_word(exp_q[0]));
        chk("pop_pc4", InstrPC4, exp_q[0] + 32'd4);
        void'(exp_q.pop_front());
        exp_pc = exp_pc + 32'd4;
        exp_fetch++;
        n_pop++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (InstrValid) break;
      @(negedge Clock);
    end
  endtask

  task automatic wait_pc(input logic [31:0] pc, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (InstrValid && InstrPC == pc) break;
      @(negedge Clock);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;

    // Reset values
    repeat (3) @(negedge Clock);
    chk("rst_req", IMemReq, 32'd0);
    chk("rst_valid", InstrValid, 32'd0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_pc", InstrPC, 32'h0);
    chk("rst_pc4", InstrPC4, 32'h0);
    chk("rst_state", o_dbg_state, IDLE);
    #2 nReset = 1'b1;

    // 1: latency 1, no stall
    @(negedge Clock);
    chk("t1_state_fetch", o_dbg_state, FETCH);
    chk("t1_req", IMemReq, 32'd1);
    chk("t1_addr0", IMemAddr, 32'h0);
    chk("t1_bubble1", InstrValid, 32'd0);
    @(negedge Clock);
    chk("t1_bubble2", InstrValid, 32'd0);
    @(negedge Clock);
    chk("t1_valid0", InstrValid, 32'd1);
    chk("t1_pc0", InstrPC, 32'h0);
    chk("t1_instr0", Instr, mem_word(32'h0));
    chk("t1_pc4_0", InstrPC4, 32'h4);
    @(negedge Clock);
    chk("t1_valid4", InstrValid, 32'd1);
    chk("t1_pc4", InstrPC, 32'h4);

    // 2: stall 4 cycles on PC 0x8
    wait_pc(32'h8, 10);
    chk("t2_reach8", InstrPC, 32'h8);
    Stall = 1'b1;
    repeat (4) begin
      @(negedge Clock);
      chk("t2_hold_pc", InstrPC, 32'h8);
      chk("t2_hold_instr", Instr, mem_word(32'h8));
      chk("t2_hold_valid", InstrValid, 32'd1);
    end
    chk("t2_full_noreq", IMemReq, 32'd0);
    Stall = 1'b0;
    @(negedge Clock);
    chk("t2_release_pc", InstrPC, 32'hC);
    chk("t2_release_valid", InstrValid, 32'd1);

    // 3: redirect with two reads in flight, latency 3
    lat = 3;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      #2;
      if (mem_q.size() == 2 && !IMemRValid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t3_two_inflight", 32'(ok), 32'd1);
    RedirectPC = 32'h100;
    Redirect = 1'b1;
    @(negedge Clock);
    Redirect = 1'b0;
    chk("t3_bubble", InstrValid, 32'd0);
    chk("t3_state_drain", o_dbg_state, DRAIN);
    wait_valid(20);
    chk("t3_pc", InstrPC, 32'h100);
    chk("t3_pc4", InstrPC4, 32'h104);
    chk("t3_instr", Instr, mem_word(32'h100));
    chk("t3_state_fetch", o_dbg_state, FETCH);

    // 4: redirect coincident with ack and rvalid, then again while draining
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      #2;
      if (IMemAck && IMemRValid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_ack_and_rvalid", 32'(ok), 32'd1);
    RedirectPC = 32'h180;
    Redirect = 1'b1;
    @(negedge Clock);
    chk("t4_bubble", InstrValid, 32'd0);
    chk("t4_state_drain", o_dbg_state, DRAIN);
    RedirectPC = 32'h200;
    @(negedge Clock);
    Redirect = 1'b0;
    chk("t4_bubble2", InstrValid, 32'd0);
    wait_valid(20);
    chk("t4_pc", InstrPC, 32'h200);
    chk("t4_instr", Instr, mem_word(32'h200));

    // PC wrap and ignored low RedirectPC bits
    RedirectPC = 32'hFFFF_FFFB;
    Redirect = 1'b1;
    @(negedge Clock);
    Redirect = 1'b0;
    wait_valid(20);
    chk("wrap_first_pc", InstrPC, 32'hFFFF_FFF8);
    wait_pc(32'hFFFF_FFFC, 10);
    chk("wrap_reach_fffc", InstrPC, 32'hFFFF_FFFC);
    chk("wrap_pc4", InstrPC4, 32'h0);
    wait_pc(32'h0, 10);
    chk("wrap_zero_valid", InstrValid, 32'd1);
    chk("wrap_zero_instr", Instr, mem_word(32'h0));

    // 5: random back-pressure, stalls and redirects
    ack_pct = 70;
    rv_pct = 70;
    lat = 2;
    n_pop = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge Clock);
      Stall = ($urandom_range(99) < 25);
      #2;
      Redirect = ($urandom_range(99) < 3);
      RedirectPC = $urandom;
    end
    @(negedge Clock);
    Stall = 1'b0;
    Redirect = 1'b0;
    ack_pct = 100;
    rv_pct = 100;
    repeat (20) @(negedge Clock);
    chk("t5_progress", 32'(n_pop > 500), 32'd1);

`ifdef FETCH_PERF_CNT_EN
    // 6: performance counters against the bench's own tallies
    chk("t6_fetch_count", FetchCount, 32'(exp_fetch));
    chk("t6_bubble_count", BubbleCount, 32'(exp_bubble));
`endif

    // Reset in the middle of traffic
    repeat (6) @(negedge Clock);
    #2 nReset = 1'b0;
    @(negedge Clock);
    chk("rst2_valid", InstrValid, 32'd0);
    chk("rst2_req", IMemReq, 32'd0);
    chk("rst2_instr", Instr, 32'h0);
    chk("rst2_state", o_dbg_state, IDLE);
    #2 nReset = 1'b1;
    @(negedge Clock);
    wait_valid(20);
    chk("rst2_first_pc", InstrPC, 32'h0);
    @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
